// File: rtl/wb_burst_master_pkg.sv
// Shared types and constants for the Wishbone burst master and its write FIFO.
package wb_burst_master_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 26;
    localparam int MAXB_DEF = 16;
    localparam int TMO_DEF  = 255;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2,
        FINISH    = 2'd3
    } state_t;

    // Cycle type for beat index `beat` of a burst of len+1 beats.
    function automatic logic [2:0] beat_cti(input logic [3:0] beat, input logic [3:0] len);
        logic [2:0] cti;
        if (len == 4'd0) begin
            cti = CTI_CLASSIC;
        end else if (beat == len) begin
            cti = CTI_EOB;
        end else begin
            cti = CTI_INCR;
        end
        return cti;
    endfunction

endpackage

// File: rtl/wb_burst_master_wr_fifo.sv
// Synchronous write-data FIFO; exposes head and the word behind it so the
// master can register the next beat's data on the same edge as the pop.
module wb_wr_fifo
    import wb_burst_master_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = MAXB_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [DW-1:0]              head,
    output logic [DW-1:0]              head_next,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    // DEPTH is a power of two so the pointers wrap naturally.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign head_next = mem_r[rd_ptr_r + PW'(1'b1)];

    // Storage array; entries are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; flush discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master: takes one command at a time, runs up to
// 16 beats, buffers write data in a FIFO and aborts on ack timeout.
module wb_burst_master
    import wb_burst_master_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int MAXB = MAXB_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            sdr_init_done,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [3:0]      cmd_len,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    output logic            rdat_valid,
    output logic [DW-1:0]   rdat,
    output logic            done,
    output logic            err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i
);
    localparam int TW = $clog2(TMO + 1);
    localparam int CW = $clog2(MAXB + 1);
    localparam int SW = DW / 8;

    state_t          state_r, state_s;
    logic [3:0]      len_r, len_s, beat_r, beat_s;
    logic            we_r, we_s;
    logic [SW-1:0]   sel_r, sel_s;
    logic [AW-3:0]   base_r, base_s;
    logic [TW-1:0]   tmo_r, tmo_s;
    logic            cyc_r, cyc_s, wb_we_r, wb_we_s;
    logic [AW-1:0]   wb_addr_r, wb_addr_s;
    logic [DW-1:0]   wb_dat_r, wb_dat_s, rdat_r, rdat_s;
    logic [SW-1:0]   wb_sel_r, wb_sel_s;
    logic [2:0]      wb_cti_r, wb_cti_s;
    logic            rdat_valid_r, rdat_valid_s, done_r, done_s, err_r, err_s;
    logic            cmd_ready_r, cmd_ready_s;
    logic            pop_s, flush_s, fifo_full_s;
    logic [DW-1:0]   fifo_head_s, fifo_head_next_s;
    logic [CW-1:0]   fifo_count_s;
    logic            unused_addr_s;

    assign unused_addr_s = ^cmd_addr[1:0];

    wb_wr_fifo #(.DW(DW), .DEPTH(MAXB)) u_wr_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_i),
        .push      (wdat_valid),
        .wdata     (wdat),
        .pop       (pop_s),
        .flush     (flush_s),
        .head      (fifo_head_s),
        .head_next (fifo_head_next_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    assign wdat_ready = !fifo_full_s;
    assign cmd_ready  = cmd_ready_r;
    assign wb_cyc_o   = cyc_r;
    assign wb_stb_o   = cyc_r;
    assign wb_we_o    = wb_we_r;
    assign wb_addr_o  = wb_addr_r;
    assign wb_dat_o   = wb_dat_r;
    assign wb_sel_o   = wb_sel_r;
    assign wb_cti_o   = wb_cti_r;
    assign rdat       = rdat_r;
    assign rdat_valid = rdat_valid_r;
    assign done       = done_r;
    assign err        = err_r;

    // Next-state and next values of every registered output.
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        we_s         = we_r;
        sel_s        = sel_r;
        base_s       = base_r;
        beat_s       = beat_r;
        tmo_s        = tmo_r;
        cyc_s        = cyc_r;
        wb_we_s      = wb_we_r;
        wb_addr_s    = wb_addr_r;
        wb_dat_s     = wb_dat_r;
        wb_sel_s     = wb_sel_r;
        wb_cti_s     = wb_cti_r;
        rdat_s       = rdat_r;
        rdat_valid_s = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;
        pop_s        = 1'b0;
        flush_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    len_s  = cmd_len;
                    we_s   = cmd_we;
                    sel_s  = cmd_sel;
                    base_s = cmd_addr[AW-1:2];
                    if (!cmd_we || (fifo_count_s >= (CW'(cmd_len) + CW'(1'b1)))) begin
                        state_s = BURST;
                    end else begin
                        state_s = WAIT_DATA;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_DATA: begin
                if (fifo_count_s >= (CW'(len_r) + CW'(1'b1))) begin
                    state_s = BURST;
                end else begin
                    state_s = WAIT_DATA;
                end
            end
            BURST: begin
                if (!cyc_r) begin
                    cyc_s     = 1'b1;
                    beat_s    = 4'd0;
                    tmo_s     = {TW{1'b0}};
                    wb_we_s   = we_r;
                    wb_sel_s  = sel_r;
                    wb_addr_s = {base_r, 2'b00};
                    wb_dat_s  = fifo_head_s;
                    wb_cti_s  = beat_cti(4'd0, len_r);
                end else if (wb_ack_i) begin
                    tmo_s = {TW{1'b0}};
                    if (we_r) begin
                        pop_s = 1'b1;
                    end else begin
                        rdat_s       = wb_dat_i;
                        rdat_valid_s = 1'b1;
                    end
                    if (beat_r == len_r) begin
                        cyc_s   = 1'b0;
                        done_s  = 1'b1;
                        state_s = FINISH;
                    end else begin
                        beat_s    = beat_r + 4'd1;
                        wb_addr_s = wb_addr_r + AW'(3'd4);
                        wb_dat_s  = fifo_head_next_s;
                        wb_cti_s  = beat_cti(beat_r + 4'd1, len_r);
                    end
                end else if (tmo_r == TW'(TMO)) begin
                    // Abort: leftover write data belongs to the dead burst.
                    cyc_s   = 1'b0;
                    flush_s = 1'b1;
                    err_s   = 1'b1;
                    tmo_s   = {TW{1'b0}};
                    state_s = IDLE;
                end else begin
                    tmo_s = tmo_r + TW'(1'b1);
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cyc_s   = 1'b0;
            end
        endcase
        cmd_ready_s = (state_s == IDLE) && sdr_init_done;
    end

    // FSM state and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r      <= IDLE;
            len_r        <= 4'd0;
            we_r         <= 1'b0;
            sel_r        <= {SW{1'b0}};
            base_r       <= {(AW-2){1'b0}};
            beat_r       <= 4'd0;
            tmo_r        <= {TW{1'b0}};
            cyc_r        <= 1'b0;
            wb_we_r      <= 1'b0;
            wb_addr_r    <= {AW{1'b0}};
            wb_dat_r     <= {DW{1'b0}};
            wb_sel_r     <= {SW{1'b0}};
            wb_cti_r     <= CTI_CLASSIC;
            rdat_r       <= {DW{1'b0}};
            rdat_valid_r <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            cmd_ready_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            we_r         <= we_s;
            sel_r        <= sel_s;
            base_r       <= base_s;
            beat_r       <= beat_s;
            tmo_r        <= tmo_s;
            cyc_r        <= cyc_s;
            wb_we_r      <= wb_we_s;
            wb_addr_r    <= wb_addr_s;
            wb_dat_r     <= wb_dat_s;
            wb_sel_r     <= wb_sel_s;
            wb_cti_r     <= wb_cti_s;
            rdat_r       <= rdat_s;
            rdat_valid_r <= rdat_valid_s;
            done_r       <= done_s;
            err_r        <= err_s;
            cmd_ready_r  <= cmd_ready_s;
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized bench for wb_burst_master with a queue-based reference model.
module tb_wb_burst_master;
    localparam int DW = 32;
    localparam int AW = 26;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i, sdr_init_done, cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [3:0]      cmd_len, cmd_sel;
    logic            wdat_valid, wdat_ready, rdat_valid, done, err;
    logic [DW-1:0]   wdat, rdat, wb_dat_o, wb_dat_i;
    logic            wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [AW-1:0]   wb_addr_o;
    logic [3:0]      wb_sel_o;
    logic [2:0]      wb_cti_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_burst_master #(.DW(DW), .AW(AW), .MAXB(16), .TMO(255)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .sdr_init_done(sdr_init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rdat_valid(rdat_valid), .rdat(rdat), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cnt_done = 0;
    int cnt_err = 0;
    logic [31:0] got_rd[$];
    logic [31:0] wq[$];
    logic        c_we;
    logic [AW-1:0] c_addr;
    logic [3:0]  c_len, c_sel;
    int          ack_pct = 100;
    int          drop_init_beat = -1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: records every read beat, done and err pulse.
    always @(negedge wb_clk_i) begin
        if (rdat_valid) got_rd.push_back(rdat);
        if (done) cnt_done++;
        if (err) cnt_err++;
    end

    task automatic push_word(input logic [31:0] d);
        @(negedge wb_clk_i);
        wdat_valid = 1'b1;
        wdat = d;
        check_val("wdat_ready", wdat_ready, wq.size() < 16);
        if (wq.size() < 16) wq.push_back(d);
        @(posedge wb_clk_i);
        #1 wdat_valid = 1'b0;
    endtask

    task automatic issue_cmd(input logic we, input logic [AW-1:0] addr, input logic [3:0] len,
                             input logic [3:0] sel);
        int k = 0;
        c_we = we; c_addr = addr; c_len = len; c_sel = sel;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_sel = sel;
        while (!cmd_ready && k < 50) begin
            @(negedge wb_clk_i);
            k++;
        end
        check_val("cmd_ready", cmd_ready, 1'b1);
        @(posedge wb_clk_i);
        #1 cmd_valid = 1'b0;
    endtask

    // Acts as the Wishbone slave for the current command and checks each beat.
    task automatic serve_burst();
        int beat = 0;
        int cyc_n = 0;
        int rd_base = got_rd.size();
        int done0 = cnt_done;
        int err0 = cnt_err;
        logic [31:0] exp_rd[$];
        logic [31:0] d, ew;
        longint ea;
        while (beat <= int'(c_len) && cyc_n < 3000) begin
            @(negedge wb_clk_i);
            cyc_n++;
            wb_ack_i = 1'b0;
            if (beat == drop_init_beat) sdr_init_done = 1'b0;
            cmd_valid = (beat < int'(c_len)) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_we = 1'($urandom); cmd_addr = AW'($urandom); cmd_len = 4'($urandom); cmd_sel = 4'($urandom);
            if (wb_cyc_o && wb_stb_o && $urandom_range(0, 99) < ack_pct) begin
                d = $urandom;
                wb_ack_i = 1'b1;
                wb_dat_i = d;
                ea = (((longint'(c_addr) >> 2) + beat) % (longint'(1) << (AW - 2))) * 4;
                check_val("addr", wb_addr_o, ea);
                check_val("cti", wb_cti_o, (c_len == 0) ? 3'b000 : ((beat == c_len) ? 3'b111 : 3'b010));
                check_val("we", wb_we_o, c_we);
                check_val("sel", wb_sel_o, c_sel);
                if (c_we) begin
                    if (wq.size() > 0) ew = wq.pop_front();
                    else ew = 32'hDEAD_BEEF;
                    check_val("dat_o", wb_dat_o, ew);
                end else begin
                    exp_rd.push_back(d);
                end
                beat++;
            end
        end
        check_val("beats", beat, c_len + 1);
        @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        cmd_valid = 1'b0;
        check_val("cyc_drop", wb_cyc_o, 1'b0);
        check_val("done_lat", done, 1'b1);
        @(negedge wb_clk_i);
        check_val("cmd_ready_after", cmd_ready, sdr_init_done);
        @(negedge wb_clk_i);
        check_val("done_cnt", cnt_done - done0, 1);
        check_val("err_cnt", cnt_err - err0, 0);
        check_val("rd_cnt", got_rd.size() - rd_base, exp_rd.size());
        for (int i = 0; i < exp_rd.size() && rd_base + i < got_rd.size(); i++)
            check_val("rdat", got_rd[rd_base + i], exp_rd[i]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad, seen, acks, nack, done0, err0, k;
        logic we;
        logic [3:0] len;
        wb_rst_i = 1'b0; sdr_init_done = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
        cmd_addr = '0; cmd_len = 4'd0; cmd_sel = 4'd0; wdat_valid = 1'b0; wdat = '0;
        wb_ack_i = 1'b0; wb_dat_i = '0;
        repeat (3) @(negedge wb_clk_i);
        check_val("rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
        check_val("rst_addr", wb_addr_o, 0);
        check_val("rst_dat_sel_cti", {wb_dat_o, wb_sel_o, wb_cti_o}, 0);
        check_val("rst_rdat", {rdat, rdat_valid, done, err}, 0);
        check_val("rst_wdat_ready", wdat_ready, 1'b1);
        wb_rst_i = 1'b1;

        // Init gate, then single-beat read at top of address space
        c_we = 1'b0; c_addr = 26'h3FF_FFFC; c_len = 4'd0; c_sel = 4'hF;
        cmd_valid = 1'b1; cmd_we = c_we; cmd_addr = c_addr; cmd_len = c_len; cmd_sel = c_sel;
        bad = 0;
        repeat (6) begin
            @(negedge wb_clk_i);
            if (cmd_ready || wb_cyc_o) bad++;
        end
        check_val("init_gate", bad, 0);
        sdr_init_done = 1'b1;
        @(negedge wb_clk_i);
        check_val("init_ready", cmd_ready, 1'b1);
        @(posedge wb_clk_i);
        #1 cmd_valid = 1'b0;
        serve_burst();

        // Write x4 at 0x100, ack every cycle
        for (int i = 0; i < 4; i++) push_word(32'hA0 + i);
        ack_pct = 100;
        issue_cmd(1'b1, 26'h100, 4'd3, 4'hF);
        serve_burst();

        // Write x3 with only two words available
        push_word(32'hB0);
        push_word(32'hB1);
        issue_cmd(1'b1, 26'h2002, 4'd2, 4'h3);
        bad = 0;
        repeat (8) begin
            @(negedge wb_clk_i);
            if (wb_cyc_o) bad++;
        end
        check_val("wait_data_hold", bad, 0);
        push_word(32'hB2);
        serve_burst();

        // Read x8 wrapping past the top of the address space
        issue_cmd(1'b0, 26'h3FF_FFF8, 4'd7, 4'hF);
        serve_burst();

        // FIFO full: 17th push is dropped, then a 16-beat write drains it
        for (int i = 0; i < 17; i++) push_word(32'hC000 + i);
        ack_pct = 60;
        issue_cmd(1'b1, 26'h0AB_CDE4, 4'd15, 4'h5);
        serve_burst();

        // sdr_init_done falls mid-burst
        ack_pct = 50;
        drop_init_beat = 2;
        issue_cmd(1'b0, 26'h40, 4'd7, 4'hF);
        serve_burst();
        drop_init_beat = -1;
        bad = 0;
        repeat (3) begin
            @(negedge wb_clk_i);
            if (cmd_ready) bad++;
        end
        check_val("init_low_block", bad, 0);
        sdr_init_done = 1'b1;

        // Ack timeout after one beat
        for (int i = 0; i < 6; i++) push_word(32'hD0 + i);
        issue_cmd(1'b1, 26'h80, 4'd3, 4'hF);
        done0 = cnt_done; err0 = cnt_err;
        seen = 0; acks = 0; nack = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge wb_clk_i);
            wb_ack_i = 1'b0;
            if (wb_cyc_o) begin
                seen = 1;
                if (acks == 0) begin
                    wb_ack_i = 1'b1;
                    acks = 1;
                    check_val("tmo_dat0", wb_dat_o, wq.pop_front());
                end else begin
                    nack++;
                end
            end else if (seen != 0) begin
                break;
            end
        end
        check_val("tmo_cyc", wb_cyc_o, 1'b0);
        check_val("tmo_err", err, 1'b1);
        check_val("tmo_nack", nack, 256);
        check_val("tmo_done", done, 1'b0);
        wq.delete();
        @(negedge wb_clk_i);
        check_val("tmo_cmd_ready", cmd_ready, 1'b1);
        @(negedge wb_clk_i);
        check_val("tmo_err_cnt", cnt_err - err0, 1);
        check_val("tmo_done_cnt", cnt_done - done0, 0);
        ack_pct = 100;
        push_word(32'hE0);
        issue_cmd(1'b1, 26'h84, 4'd0, 4'hF);
        serve_burst();

        // Reset mid-burst
        push_word(32'hF0);
        push_word(32'hF1);
        issue_cmd(1'b0, 26'h200, 4'd7, 4'hF);
        done0 = cnt_done; err0 = cnt_err;
        k = 0;
        while (!wb_cyc_o && k < 10) begin
            @(negedge wb_clk_i);
            k++;
        end
        check_val("rst_pre_cyc", wb_cyc_o, 1'b1);
        #2 wb_rst_i = 1'b0;
        #1 check_val("rst_async_cyc", wb_cyc_o, 1'b0);
        wq.delete();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        check_val("rst_ready", cmd_ready, 1'b1);
        check_val("rst_no_pulse", (cnt_done - done0) + (cnt_err - err0), 0);
        push_word(32'h5A5A_0001);
        issue_cmd(1'b1, 26'h300, 4'd0, 4'h9);
        serve_burst();

        // Randomized bursts
        repeat (25) begin
            we = 1'($urandom);
            len = 4'($urandom_range(0, 15));
            ack_pct = $urandom_range(25, 100);
            if (we) begin
                for (int i = 0; i < int'(len) + 1 + $urandom_range(0, 2); i++) push_word($urandom);
            end else begin
                for (int i = 0; i < $urandom_range(0, 1); i++) push_word($urandom);
            end
            issue_cmd(we, AW'($urandom), len, 4'($urandom));
            serve_burst();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
